movegen_pos_loader: RTL and testbench
=====================================

Name: movegen_pos_loader

Overview:
- Transmit end of the serial position chain that loads the movegen square array.
- Holds a 64-square board image. Software or the search controller writes it randomly, one square at a time.
- On `start`, shifts all 64 nibbles into the chain with `out_pos_valid`, then publishes side-to-move and castle rights in the same cycle as `done`, so the board and flags change together.
- Also captures the nibbles returning from the chain tail, giving a readback of the position the chain held before the load.

Parameters:
- NSQ, 64, number of squares in the chain. The square index width is $clog2(NSQ).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write one square of the board image
- wr_addr  in  6  square index = (rank-1)*8 + (file-1); a1=0, h8=63
- wr_data  in  4  piece code: bit3 = colour (1 = white), bits2:0 = K1 Q2 R3 B4 N5 P6, 0 = empty
- wr_err  out  1  one-cycle pulse: write attempted while busy
- i_wtp  in  1  side to move for the next position
- i_castle_rights  in  4  castle rights for the next position
- start  in  1  begin shift; honoured only when idle
- busy  out  1  shift in progress
- done  out  1  one-cycle pulse after the last nibble is shifted
- out_pos_valid  out  1  chain shift enable (drives `in_pos_valid` of the chain head)
- out_pos_data  out  4  chain data (drives `in_pos_data` of the chain head)
- in_chain_data  in  4  `out_pos_data` of the chain tail (square 63)
- rd_addr  in  6  readback square index
- rd_data  out  4  captured previous chain content at `rd_addr` (combinational read)
- o_wtp  out  1  published side to move
- o_castle_rights  out  4  published castle rights

Behaviour:
- Reset values:
  - State IDLE.
  - busy, done, wr_err, out_pos_valid = 0; out_pos_data = 0.
  - Board image and readback image all zero.
  - o_wtp = 0, o_castle_rights = 0; shift counter = 0.
  - Reset during SHIFT aborts immediately: valid drops the next edge and no `done` is produced. The chain holds a partial shift; the controller must reload.
- Writes:
  - In IDLE, `wr_en` stores `wr_data` at `wr_addr` at the clock edge.
  - In SHIFT, writes are ignored and `wr_err` pulses the next cycle.
  - A write and a `start` in the same IDLE cycle: the write lands first, and the shift uses the new value.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start` = 1 → SHIFT, counter k = 0.
  - Latch `i_wtp` and `i_castle_rights` into pending registers.
- SHIFT (exactly NSQ cycles, k = 0..NSQ-1):
  - busy = 1, out_pos_valid = 1, out_pos_data = image[NSQ-1-k], registered outputs.
  - First transmitted nibble is square 63; the last is square 0.
  - After NSQ valid cycles every chain square i holds image[i].
  - In each valid cycle, `in_chain_data` (the tail's registered value before that edge) is written to readback[NSQ-1-k]. The readback therefore equals the chain's pre-load position.
  - When k = NSQ-1 → DONE.
- DONE (one cycle):
  - busy = 0, out_pos_valid = 0, done = 1.
  - o_wtp and o_castle_rights update from the pending registers in this same cycle.
  - → IDLE.
- `start` while busy or in DONE is ignored; it is not queued.
- The first `start` after `done` is accepted the cycle after DONE. Back-to-back load period is NSQ+2 cycles.
- out_pos_valid is never asserted outside SHIFT. It never gaps inside SHIFT; there is no stall input and the chain always accepts.
- The counter does not wrap mid-operation; the terminal count is detected at NSQ-1.
- `rd_data` is valid any time; it reflects the last completed or partial capture.

Test Plan:
- After reset, write image[i] = i[3:0] for all 64 squares, then `start`.
  - 64 consecutive valid cycles with data 0xF, 0xE, …, 0x0 (square 63 first).
  - done asserts exactly at cycle 66 after start; chain square i holds i[3:0].
- Load the standard initial position with i_wtp = 1, i_castle_rights = 4'hF.
  - Chain e1 = 0x9, e8 = 0x1, e2 = 0xE, d7 = 0x6.
  - o_wtp stays 0 until the DONE cycle, then = 1 together with done.
- Two back-to-back loads A then B.
  - Readback after B equals image A for all 64 squares.
  - The second start, issued during busy, is ignored; when issued after done it is accepted, giving a 66-cycle period.
- wr_en to square 10 at shift cycle 20.
  - wr_err pulses one cycle later; image[10] is unchanged, and the next load shows the old value.
- Assert rst at shift cycle 30.
  - Next cycle: valid = 0, busy = 0, no done.
  - o_castle_rights = 0, readback all 0.
  - A subsequent start performs a full 64-cycle load.
- Write to square 63 and `start` in the same cycle.
  - The first transmitted nibble equals the new value.

Source files
------------

// File: rtl/movegen_pos_loader.sv
// movegen_pos_loader: board image store that serially loads the movegen square chain
module movegen_pos_loader #(
    parameter int NSQ = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [$clog2(NSQ)-1:0] wr_addr,
    input  logic [3:0]             wr_data,
    output logic                   wr_err,
    input  logic                   i_wtp,
    input  logic [3:0]             i_castle_rights,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   out_pos_valid,
    output logic [3:0]             out_pos_data,
    input  logic [3:0]             in_chain_data,
    input  logic [$clog2(NSQ)-1:0] rd_addr,
    output logic [3:0]             rd_data,
    output logic                   o_wtp,
    output logic [3:0]             o_castle_rights
);
    localparam int AW = $clog2(NSQ);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [AW-1:0] K_LAST = AW'(NSQ - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_k;
    logic [3:0]    r_img [NSQ];
    logic [3:0]    r_rb  [NSQ];
    logic          r_busy;
    logic          r_done;
    logic          r_wr_err;
    logic          r_valid;
    logic [3:0]    r_data;
    logic          r_pend_wtp;
    logic [3:0]    r_pend_cr;
    logic          r_wtp;
    logic [3:0]    r_cr;

    logic          w_idle;
    logic          w_wr;
    logic          w_last;
    logic [AW-1:0] w_tx_idx;
    logic [AW-1:0] w_nx_idx;
    logic [3:0]    w_first;

    assign w_idle   = r_state == S_IDLE;
    assign w_wr     = wr_en & w_idle;
    assign w_last   = r_k == K_LAST;
    // square currently on the chain input, and the one that follows it
    assign w_tx_idx = K_LAST - r_k;
    assign w_nx_idx = w_tx_idx - AW'(1);
    // a write landing in the start cycle must be visible to the first nibble
    assign w_first  = (w_wr && wr_addr == K_LAST) ? wr_data : r_img[K_LAST];

    assign busy            = r_busy;
    assign done            = r_done;
    assign wr_err          = r_wr_err;
    assign out_pos_valid   = r_valid;
    assign out_pos_data    = r_data;
    assign o_wtp           = r_wtp;
    assign o_castle_rights = r_cr;
    assign rd_data         = r_rb[rd_addr];

    // board image: random writes accepted only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSQ; i++) r_img[i] <= 4'h0;
        end else if (w_wr) begin
            r_img[wr_addr] <= wr_data;
        end
    end

    // readback: the tail nibble leaving the chain lands at the square being loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSQ; i++) r_rb[i] <= 4'h0;
        end else if (r_state == S_SHIFT) begin
            r_rb[w_tx_idx] <= in_chain_data;
        end
    end

    // load sequencer: IDLE -> SHIFT (NSQ beats, square NSQ-1 first) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 4'h0;
            r_pend_wtp <= 1'b0;
            r_pend_cr  <= 4'h0;
            r_wtp      <= 1'b0;
            r_cr       <= 4'h0;
        end else begin
            r_wr_err <= wr_en & ~w_idle;
            r_done   <= 1'b0;
            if (w_idle) begin
                r_pend_wtp <= i_wtp;
                r_pend_cr  <= i_castle_rights;
                if (start) begin
                    r_state <= S_SHIFT;
                    r_k     <= '0;
                    r_busy  <= 1'b1;
                    r_valid <= 1'b1;
                    r_data  <= w_first;
                end
            end else if (r_state == S_SHIFT) begin
                if (w_last) begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_data  <= 4'h0;
                    r_done  <= 1'b1;
                    r_wtp   <= r_pend_wtp;
                    r_cr    <= r_pend_cr;
                end else begin
                    r_k    <= r_k + AW'(1);
                    r_data <= r_img[w_nx_idx];
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_movegen_pos_loader.sv
// tb_movegen_pos_loader: directed checks of the position loader against a chain model
module tb_movegen_pos_loader;
    logic       clk = 1'b0;
    logic       rst, wr_en, wr_err, i_wtp, start, busy, done, out_pos_valid, o_wtp;
    logic [5:0] wr_addr, rd_addr;
    logic [3:0] wr_data, i_castle_rights, out_pos_data, in_chain_data, rd_data, o_castle_rights;

    logic [3:0] chain [64] = '{default: 4'h0};
    logic [3:0] tx [64];
    logic [3:0] exp_img [64];
    logic [3:0] exp_rb [64];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_valid, done_at, werr_at, t_start, busy_bad, t_a, dn;
    bit wtp_pre;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external chain: 64 nibble stages shifting on valid, square 63 is the tail
    always @(posedge clk) begin
        if (out_pos_valid) begin
            for (int i = 63; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= out_pos_data;
        end
    end
    assign in_chain_data = chain[63];

    movegen_pos_loader dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .i_wtp(i_wtp), .i_castle_rights(i_castle_rights), .start(start),
        .busy(busy), .done(done), .out_pos_valid(out_pos_valid), .out_pos_data(out_pos_data),
        .in_chain_data(in_chain_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .o_wtp(o_wtp), .o_castle_rights(o_castle_rights)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_img();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = exp_img[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    // pulses start, then follows the shift until done (bounded); returns in the done cycle
    task automatic load(input int mid, input int wat, input logic [3:0] wval);
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0; t_start = cyc;
        n_valid = 0; done_at = 0; werr_at = 0; wtp_pre = 0; busy_bad = 0;
        for (int c = 2; c <= 100 && done_at == 0; c++) begin
            if (out_pos_valid) begin
                if (n_valid < 64) tx[n_valid] = out_pos_data;
                n_valid++;
                if (!busy) busy_bad++;
            end
            if (wr_err) werr_at = c;
            if (done) done_at = c;
            else begin
                if (o_wtp) wtp_pre = 1;
                start = (c == mid);
                wr_en = (c == wat); wr_addr = 6'd10; wr_data = wval;
                tick();
            end
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic tx_check(input string tag);
        int bad = 0;
        for (int j = 0; j < 64; j++) if (tx[j] !== exp_img[63-j]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic chain_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (chain[i] !== exp_img[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic rb_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            if (rd_data !== exp_rb[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pc [8];
        pc = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; i_wtp = 1'b0;
        i_castle_rights = '0; start = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_err", 32'(wr_err), 0);
        check("rst_valid", 32'(out_pos_valid), 0);
        check("rst_data", 32'(out_pos_data), 0);
        check("rst_wtp", 32'(o_wtp), 0);
        check("rst_castle", 32'(o_castle_rights), 0);
        for (int i = 0; i < 64; i++) exp_rb[i] = 4'h0;
        rb_check("rst_readback");
        rst = 1'b0;
        tick();

        // ramp image: square i holds i[3:0]
        for (int i = 0; i < 64; i++) exp_img[i] = 4'(i);
        write_img();
        load(0, 0, 4'h0);
        check("ramp_valid_beats", n_valid, 64);
        check("ramp_done_cycle", done_at, 66);
        check("ramp_busy_in_shift", busy_bad, 0);
        check("ramp_first_nibble", 32'(tx[0]), 'hF);
        check("ramp_last_nibble", 32'(tx[63]), 'h0);
        tx_check("ramp_tx_order");
        check("ramp_done_busy", 32'(busy), 0);
        check("ramp_done_valid", 32'(out_pos_valid), 0);
        tick();
        check("ramp_done_pulse", 32'(done), 0);
        chain_check("ramp_chain");
        rb_check("ramp_readback");

        // standard initial position, white to move, all castle rights
        for (int i = 0; i < 64; i++) exp_rb[i] = exp_img[i];
        for (int i = 0; i < 64; i++)
            exp_img[i] = i < 8 ? (4'h8 | pc[i]) : i < 16 ? 4'hE :
                         i >= 56 ? pc[i-56] : i >= 48 ? 4'h6 : 4'h0;
        write_img();
        i_wtp = 1'b1; i_castle_rights = 4'hF;
        tick();
        check("std_wtp_before", 32'(o_wtp), 0);
        load(0, 0, 4'h0);
        check("std_done_cycle", done_at, 66);
        check("std_wtp_early", 32'(wtp_pre), 0);
        check("std_wtp_with_done", 32'(o_wtp), 1);
        check("std_castle_with_done", 32'(o_castle_rights), 'hF);
        tick();
        check("std_e1", 32'(chain[4]), 'h9);
        check("std_e8", 32'(chain[60]), 'h1);
        check("std_e2", 32'(chain[12]), 'hE);
        check("std_d7", 32'(chain[51]), 'h6);
        check("std_d1", 32'(chain[3]), 'hA);
        chain_check("std_chain");
        rb_check("std_readback");

        // back-to-back: A with an ignored start mid-shift, then B with sq63 written at start
        for (int i = 0; i < 64; i++) exp_rb[i] = exp_img[i];
        for (int i = 0; i < 64; i++) exp_img[i] = 4'(i * 3 + 1);
        write_img();
        load(12, 0, 4'h0);
        t_a = t_start;
        check("a_done_cycle", done_at, 66);
        tx_check("a_tx_order");
        tick();
        check("a_no_requeue_valid", 32'(out_pos_valid), 0);
        check("a_no_requeue_busy", 32'(busy), 0);
        for (int i = 0; i < 64; i++) exp_rb[i] = exp_img[i];
        exp_img[63] = 4'h7;
        wr_en = 1'b1; wr_addr = 6'd63; wr_data = 4'h7;
        load(0, 0, 4'h0);
        check("b_period", t_start - t_a, 66);
        check("b_first_is_new_write", 32'(tx[0]), 'h7);
        check("b_done_cycle", done_at, 66);
        tx_check("b_tx_order");
        tick();
        chain_check("b_chain");
        rb_check("b_readback_is_a");

        // write during shift is rejected and flagged
        for (int i = 0; i < 64; i++) exp_rb[i] = exp_img[i];
        load(0, 22, 4'h0);
        check("werr_cycle", werr_at, 23);
        check("werr_sq10_chain", 32'(chain[10]), 'hF);
        tick();
        check("werr_pulse_gone", 32'(wr_err), 0);
        load(0, 0, 4'h0);
        check("werr_next_load_sq10", 32'(tx[53]), 'hF);
        tx_check("werr_next_load_tx");
        tick();
        rb_check("werr_readback");

        // reset in the middle of a shift
        check("pre_rst_castle", 32'(o_castle_rights), 'hF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c < 32; c++) tick();
        check("mid_valid_before_rst", 32'(out_pos_valid), 1);
        rst = 1'b1;
        tick();
        check("abort_valid", 32'(out_pos_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_castle", 32'(o_castle_rights), 0);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (done || out_pos_valid) dn++;
        end
        check("abort_no_done", dn, 0);
        for (int i = 0; i < 64; i++) exp_rb[i] = 4'h0;
        rb_check("abort_readback");
        for (int i = 0; i < 64; i++) exp_img[i] = 4'h0;
        load(0, 0, 4'h0);
        check("reload_beats", n_valid, 64);
        check("reload_done_cycle", done_at, 66);
        tx_check("reload_tx");
        tick();
        chain_check("reload_chain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
